// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader
//  Purpose  : Loads a program into instruction memory over a UART byte link.
//             Sends a sync byte, receives a 32-bit big-endian word count and
//             that many big-endian words, writes each word to consecutive
//             addresses, then acknowledges the host.
//  Options  : LOADER_CHECKSUM_EN - when defined, a trailing big-endian word
//             must equal the mod-2^32 sum of the data words; a mismatch is
//             answered with 8'hEE and the loader ends in ERR.
//  Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
   parameter int         ADDR_W    = 12,
   parameter logic [7:0] SYNC_BYTE = 8'hAA,
   parameter logic [7:0] ACK_BYTE  = 8'h55
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_din,
   output logic              imem_we,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   word_cnt
);

   // Largest accepted program length: exactly fills the memory.
   localparam logic [32:0] c_max_len   = 33'd1 << ADDR_W;
   localparam logic [7:0]  c_nack_byte = 8'hEE;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_SYNC      = 4'd1,
      ST_SYNC_WAIT = 4'd2,
      ST_LEN       = 4'd3,
      ST_DATA      = 4'd4,
      ST_WRITE     = 4'd5,
      ST_ACK       = 4'd6,
      ST_ACK_WAIT  = 4'd7,
      ST_DONE      = 4'd8,
      ST_ERR       = 4'd9
`ifdef LOADER_CHECKSUM_EN
      ,
      ST_CHK       = 4'd10
`endif
   } state_t;

   state_t            r_state;
   logic              r_tx_first;   // first cycle after a tx pulse: tx_busy not yet valid
   logic [1:0]        r_byte_idx;   // position of the next byte within its word
   logic [23:0]       r_shift;      // first three bytes of the word being assembled
   logic [ADDR_W:0]   r_len;        // accepted program length in words
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]       r_sum;        // running mod-2^32 sum of the data words
   logic              r_nack;       // the reply being sent is a checksum rejection
`endif

   logic              w_rx_take;
   logic              w_last_byte;
   logic [31:0]       w_word;
   logic [ADDR_W:0]   w_cnt_next;

   // Bytes are only accepted while a length, data or checksum word is expected;
   // a byte arriving during WRITE already belongs to the following word.
   assign w_rx_take   = rx_valid && ((r_state == ST_LEN) || (r_state == ST_DATA) ||
`ifdef LOADER_CHECKSUM_EN
                                     (r_state == ST_CHK) ||
`endif
                                     (r_state == ST_WRITE));
   assign w_last_byte = w_rx_take && (r_byte_idx == 2'd3);
   assign w_word      = {r_shift, rx_data};
   assign w_cnt_next  = word_cnt + (ADDR_W+1)'(1);

   // Loader sequencer: state, byte assembly and all registered outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state    <= ST_IDLE;
         r_tx_first <= 1'b0;
         r_byte_idx <= 2'd0;
         r_shift    <= 24'd0;
         r_len      <= '0;
`ifdef LOADER_CHECKSUM_EN
         r_sum      <= 32'd0;
         r_nack     <= 1'b0;
`endif
         tx_data    <= 8'd0;
         tx_start   <= 1'b0;
         imem_addr  <= '0;
         imem_din   <= 32'd0;
         imem_we    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         word_cnt   <= '0;
      end else begin
         tx_start <= 1'b0;
         imem_we  <= 1'b0;

         if (w_rx_take) begin
            r_shift    <= {r_shift[15:0], rx_data};
            r_byte_idx <= r_byte_idx + 2'd1;
         end

         case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  word_cnt   <= '0;
                  r_byte_idx <= 2'd0;
                  r_shift    <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
                  r_sum      <= 32'd0;
                  r_nack     <= 1'b0;
`endif
                  done       <= 1'b0;
                  err        <= 1'b0;
                  busy       <= 1'b1;
                  tx_data    <= SYNC_BYTE;
                  tx_start   <= 1'b1;
                  r_state    <= ST_SYNC;
               end
            end
            ST_SYNC: begin
               r_tx_first <= 1'b1;
               r_state    <= ST_SYNC_WAIT;
            end
            ST_SYNC_WAIT: begin
               if (r_tx_first) begin
                  r_tx_first <= 1'b0;
               end else if (!tx_busy) begin
                  r_state <= ST_LEN;
               end
            end
            ST_LEN: begin
               if (w_last_byte) begin
                  if (w_word == 32'd0) begin
                     r_len <= '0;
`ifdef LOADER_CHECKSUM_EN
                     r_state  <= ST_CHK;
`else
                     tx_data  <= ACK_BYTE;
                     tx_start <= 1'b1;
                     r_state  <= ST_ACK;
`endif
                  end else if ({1'b0, w_word} > c_max_len) begin
                     busy    <= 1'b0;
                     err     <= 1'b1;
                     r_state <= ST_ERR;
                  end else begin
                     r_len   <= w_word[ADDR_W:0];
                     r_state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (w_last_byte) begin
                  imem_we   <= 1'b1;
                  imem_addr <= word_cnt[ADDR_W-1:0];
                  imem_din  <= w_word;
`ifdef LOADER_CHECKSUM_EN
                  r_sum     <= r_sum + w_word;
`endif
                  r_state   <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               word_cnt <= w_cnt_next;
               if (w_cnt_next == r_len) begin
`ifdef LOADER_CHECKSUM_EN
                  r_state  <= ST_CHK;
`else
                  tx_data  <= ACK_BYTE;
                  tx_start <= 1'b1;
                  r_state  <= ST_ACK;
`endif
               end else begin
                  r_state <= ST_DATA;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
               if (w_last_byte) begin
                  tx_start <= 1'b1;
                  r_state  <= ST_ACK;
                  if (w_word == r_sum) begin
                     tx_data <= ACK_BYTE;
                  end else begin
                     tx_data <= c_nack_byte;
                     r_nack  <= 1'b1;
                  end
               end
            end
`endif
            ST_ACK: begin
               r_tx_first <= 1'b1;
               r_state    <= ST_ACK_WAIT;
            end
            ST_ACK_WAIT: begin
               if (r_tx_first) begin
                  r_tx_first <= 1'b0;
               end else if (!tx_busy) begin
                  busy <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                  if (r_nack) begin
                     err     <= 1'b1;
                     r_state <= ST_ERR;
                  end else begin
                     done    <= 1'b1;
                     r_state <= ST_DONE;
                  end
`else
                  done    <= 1'b1;
                  r_state <= ST_DONE;
`endif
               end
            end
            default: begin
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
